kim_store_align_p: RTL and testbench
====================================

// Module: kim_store_align_p
// PURPOSE
//   Store-side counterpart of the load/immediate extension path: narrows a 32-bit register
//   value to a byte/halfword/word memory write with lane replication and byte enables.
//   Sits between EX/MEM pipeline register and data-memory write port of the pipelined MIPS core.
//   Registered, 1-cycle latency, valid/ready on both sides, 2-entry skid buffer so in_ready
//   is a pure register output. Flags misaligned and illegal-size stores instead of writing.
// PARAMETERS
//   ADDR_WIDTH  32  byte address width (>= 2)
//   DATA_WIDTH  32  data width; fixed at 32 (4 byte lanes); other values unsupported
// PORTS
//   clk            in   1           rising-edge clock
//   rst_n          in   1           asynchronous active-low reset
//   flush          in   1           sync pipeline flush; discards all held and incoming stores
//   in_valid       in   1           store request valid
//   in_ready       out  1           block can accept request this cycle
//   in_addr        in   ADDR_WIDTH  byte address of store
//   in_wdata       in   32          rt register value (data in low bits for SB/SH)
//   in_size        in   2           00=byte(SB) 01=half(SH) 10=word(SW) 11=illegal
//   out_valid      out  1           aligned store valid
//   out_ready      in   1           memory accepts store this cycle
//   out_addr       out  ADDR_WIDTH  word-aligned address (in_addr with [1:0] forced 0)
//   out_wdata      out  32          lane-replicated write data
//   out_be         out  4           byte enables, bit k = byte lane k (little-endian lanes)
//   out_misalign   out  1           address not aligned to size; out_be=0000
//   out_illegal    out  1           in_size==11; out_be=0000
// BEHAVIOUR
//   Reset: out_valid=0, in_ready=1, out_addr=0, out_wdata=0, out_be=0, out_misalign=0,
//     out_illegal=0, skid empty. Reset mid-transfer drops all held stores, no partial output.
//   Transfer: input accepted when in_valid&in_ready; output consumed when out_valid&out_ready.
//   Latency: accepted store appears on out_* next cycle when output slot empty or draining.
//   Storage: main reg (drives out_*) + skid reg. Accept with main full and not draining
//     -> goes to skid. When main drains, skid (if full) moves to main same edge.
//   in_ready = !skid_valid (registered). Order strictly FIFO; no reordering, no drop.
//   Output held stable while out_valid & !out_ready (all out_* unchanged).
//   Lane rules (a = in_addr[1:0]):
//     SB: wdata={4{d[7:0]}}, be=0001<<a, always aligned.
//     SH: wdata={2{d[15:0]}}, be= a[1]?1100:0011; misalign if a[0]=1.
//     SW: wdata=d, be=1111; misalign if a!=00.
//     size 11: out_illegal=1, be=0000, wdata=d. Illegal takes precedence over misalign.
//     Misalign: be=0000, wdata as computed from size; still a normal handshake entry.
//   flush=1: main and skid cleared (out_valid=0 next cycle), input this cycle discarded
//     even if in_valid&in_ready; flush overrides simultaneous accept/drain; in_ready=1 next.
//   Simultaneous accept+drain with skid empty: main reloads with new entry, no bubble.
//   Full (both regs valid): in_ready=0 until one drain; throughput 1 store/cycle sustained.
// TESTING
//   1 SB addr=0x1003 d=0x000000A5, out_ready=1 -> next cycle out_addr=0x1000,
//     wdata=0xA5A5A5A5, be=1000, misalign=0.
//   2 SH addr=0x2002 d=0x1234BEEF -> wdata=0xBEEFBEEF be=1100; SH addr=0x2001 ->
//     be=0000 misalign=1; SW addr=0x2002 -> misalign=1; size=11 -> illegal=1 be=0000.
//   3 Backpressure: out_ready=0, issue 3 SW back-to-back -> 2 accepted, in_ready=0 on 3rd;
//     release out_ready -> stores emerge in order, no loss/duplication, out_* stable while held.
//   4 Streaming: in_valid=1 and out_ready=1 for 100 cycles random stores -> 1 store/cycle,
//     in_ready never drops, output matches scoreboard model.
//   5 Flush with both regs full plus in_valid -> out_valid=0 next cycle, incoming dropped,
//     in_ready=1; next store after flush emerges with 1-cycle latency.
//   6 Assert rst_n=0 asynchronously mid-stall -> outputs reach reset values without clock edge;
//     after release first accepted store is the only output.

Source files
------------

// File: rtl/kim_store_align_p.sv
// Store aligner: narrows a register value to a byte/half/word memory write with lane replication and byte enables.
// One-cycle registered latency; 2-entry main+skid buffer keeps in_ready a flop output and holds out_* stable under stall.
module kim_store_align_p #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [1:0]            in_size,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic [3:0]            out_be,
  output logic                  out_misalign,
  output logic                  out_illegal
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            be;
    logic                  misalign;
    logic                  illegal;
  } store_t;

  store_t enc;
  store_t main_q;
  store_t skid_q;
  logic   main_v;
  logic   skid_v;
  logic   accept;

  // Faulted stores keep their computed data but never enable a lane.
  always_comb begin
    enc          = '0;
    enc.addr     = {in_addr[ADDR_WIDTH-1:2], 2'b00};
    enc.wdata    = in_wdata;
    case (in_size)
      2'b00: begin
        enc.wdata = {4{in_wdata[7:0]}};
        enc.be    = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        enc.wdata = {2{in_wdata[15:0]}};
        if (in_addr[0]) enc.misalign = 1'b1;
        else            enc.be       = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        if (in_addr[1:0] != 2'b00) enc.misalign = 1'b1;
        else                       enc.be       = 4'b1111;
      end
      default: enc.illegal = 1'b1;
    endcase
  end

  assign accept = in_valid & ~skid_v & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      // Output slot free this edge: the older skid entry has priority over new input.
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        main_v <= accept;
        if (accept) main_q <= enc;
      end
    end else if (accept) begin
      skid_q <= enc;
      skid_v <= 1'b1;
    end
  end

  assign in_ready     = ~skid_v;
  assign out_valid    = main_v;
  assign out_addr     = main_q.addr;
  assign out_wdata    = main_q.wdata;
  assign out_be       = main_q.be;
  assign out_misalign = main_q.misalign;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_kim_store_align_p.sv
// Bench for kim_store_align_p: queue-based reference model checked every cycle plus directed literal cases.
module tb_kim_store_align_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic [3:0]  out_be;
  logic        out_misalign;
  logic        out_illegal;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        mis;
    logic        ill;
  } exp_t;

  exp_t q[$];

  kim_store_align_p #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_size(in_size),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_wdata(out_wdata), .out_be(out_be),
    .out_misalign(out_misalign), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory-write view of a store computed from the lane rules with plain arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    exp_t e;
    int   lo;
    lo     = int'(a % 4);
    e      = '0;
    e.addr = a - 32'(lo);
    case (s)
      2'd0: begin
        e.wdata = (d & 32'hFF) * 32'h01010101;
        e.be    = 4'(1 << lo);
      end
      2'd1: begin
        e.wdata = (d & 32'hFFFF) * 32'h00010001;
        if (lo % 2 == 1) e.mis = 1'b1;
        else             e.be  = (lo == 2) ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        e.wdata = d;
        if (lo != 0) e.mis = 1'b1;
        else         e.be  = 4'b1111;
      end
      default: begin
        e.wdata = d;
        e.ill   = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Model: a FIFO of capacity 2 whose head is what the memory port must see.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      exp_t obs;
      logic acc;
      obs = {out_addr, out_wdata, out_be, out_misalign, out_illegal};
      chk("mon_out_valid", 80'(out_valid), 80'(q.size() != 0));
      chk("mon_in_ready", 80'(in_ready), 80'(q.size() < 2));
      if (out_valid && q.size() != 0) chk("mon_head", 80'(obs), 80'(q[0]));
      acc = in_valid && (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
        if (acc) q.push_back(model(in_addr, in_wdata, in_size));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    in_valid = v;
    in_addr  = a;
    in_wdata = d;
    in_size  = s;
  endtask

  task automatic dir(input string name, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                     input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] ebe,
                     input logic emis, input logic eill);
    drive(1'b1, a, d, s);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 80'(out_valid), 80'(1));
    chk({name, "_fields"}, 80'({out_addr, out_wdata, out_be, out_misalign, out_illegal}),
        80'({ea, ew, ebe, emis, eill}));
    step();
  endtask

  initial begin
    int cnt;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    #2;
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_in_ready", 80'(in_ready), 80'(1));
    chk("rst_fields", 80'({out_addr, out_wdata, out_be, out_misalign, out_illegal}), 80'(0));
    #10 rst_n = 1'b1;
    step();

    // Directed lane cases with hand-computed results.
    dir("sb_1003", 32'h1003, 32'h000000A5, 2'b00, 32'h1000, 32'hA5A5A5A5, 4'b1000, 1'b0, 1'b0);
    dir("sh_2002", 32'h2002, 32'h1234BEEF, 2'b01, 32'h2000, 32'hBEEFBEEF, 4'b1100, 1'b0, 1'b0);
    dir("sh_2001", 32'h2001, 32'h1234BEEF, 2'b01, 32'h2000, 32'hBEEFBEEF, 4'b0000, 1'b1, 1'b0);
    dir("sw_2002", 32'h2002, 32'h1234BEEF, 2'b10, 32'h2000, 32'h1234BEEF, 4'b0000, 1'b1, 1'b0);
    dir("ill_2002", 32'h2002, 32'h1234BEEF, 2'b11, 32'h2000, 32'h1234BEEF, 4'b0000, 1'b0, 1'b1);
    dir("sh_2000", 32'h2000, 32'h0000CAFE, 2'b01, 32'h2000, 32'hCAFECAFE, 4'b0011, 1'b0, 1'b0);

    // Backpressure: two stores fit, the third waits.
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'h11111111, 2'b10);
    step();
    drive(1'b1, 32'h104, 32'h22222222, 2'b10);
    step();
    drive(1'b1, 32'h108, 32'h33333333, 2'b10);
    @(negedge clk);
    chk("bp_full_in_ready", 80'(in_ready), 80'(0));
    step();
    step();
    @(negedge clk);
    chk("bp_hold_addr", 80'(out_addr), 80'(32'h100));
    chk("bp_hold_data", 80'(out_wdata), 80'(32'h11111111));
    step();
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    repeat (3) step();

    // Streaming random stores at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
      @(negedge clk);
      chk("stream_in_ready", 80'(in_ready), 80'(1));
      if (i > 0) chk("stream_out_valid", 80'(out_valid), 80'(1));
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();

    // Flush with both entries held and a store arriving.
    out_ready = 1'b0;
    drive(1'b1, 32'h300, 32'hAAAA0000, 2'b10);
    step();
    drive(1'b1, 32'h304, 32'hBBBB0000, 2'b10);
    step();
    drive(1'b1, 32'h308, 32'hCCCC0000, 2'b10);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 80'(out_valid), 80'(0));
    chk("flush_in_ready", 80'(in_ready), 80'(1));
    step();
    out_ready = 1'b1;
    dir("post_flush_sb", 32'h401, 32'h0000005A, 2'b00, 32'h400, 32'h5A5A5A5A, 4'b0010, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    drive(1'b1, 32'h500, 32'h55555555, 2'b10);
    step();
    drive(1'b1, 32'h504, 32'h66666666, 2'b10);
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 80'(out_valid), 80'(0));
    chk("arst_in_ready", 80'(in_ready), 80'(1));
    chk("arst_fields", 80'({out_addr, out_wdata, out_be, out_misalign, out_illegal}), 80'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    drive(1'b1, 32'h600, 32'h77777777, 2'b10);
    step();
    in_valid = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) begin
        cnt++;
        chk("arst_after_addr", 80'(out_addr), 80'(32'h600));
      end
      step();
    end
    chk("arst_after_count", 80'(cnt), 80'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
